// File: rtl/ct_divider.sv
// Constant-time unsigned restoring divider: one quotient bit per cycle, always WIDTH cycles.
// Results stay registered until the next completion so the initiator can sample them on finish.
module ct_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             finish
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] dvsr;
    // The restored partial remainder is always below the divisor (or, for a zero divisor,
    // holds at most the dividend), so its extra top bit is always zero and is not stored.
    logic [WIDTH-1:0] rem_w;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // The subtraction is always evaluated and the outcome picked by a mux, never a branch.
    always_comb begin
        shifted  = {rem_w, quo_w[WIDTH-1]};
        diff     = shifted - {1'b0, dvsr};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {quo_w[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            quo_w     <= '0;
            dvsr      <= '0;
            rem_w     <= '0;
            quotient  <= '0;
            remainder <= '0;
            finish    <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state <= CALC;
                    quo_w <= dividend;
                    dvsr  <= divisor;
                    rem_w <= '0;
                    cnt   <= '0;
                end
            end else begin
                quo_w <= quo_next;
                rem_w <= rem_next;
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state     <= IDLE;
                    quotient  <= quo_next;
                    remainder <= rem_next;
                    finish    <= 1'b1;
                end
            end
        end
    end

endmodule
